// File: rtl/mem_bus_master.sv
// Burst initiator for the MEMORY_64MB bus: turns a CPU-side burst request into
// READ/WRITE/ADDR sequences and owns the direction of the shared DATA bus.
module mem_bus_master #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  wdata_ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_vld_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  inout  wire  [DATA_WIDTH-1:0] mem_data_io
);

  localparam int HOLD_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD_HOLD, RD_CAP, TURN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_vld_q, rdata_vld_d;

  logic last_beat;
  logic hold_done;

  assign last_beat = (beat_q == len_q);
  assign hold_done = (hold_q == HOLD_W'(RD_LATENCY - 1));

  // The current address is not advanced past the last beat, so MEM_ADDR
  // naturally holds the final burst address while idle.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    hold_d      = hold_q;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = req_addr_i;
          len_d   = req_len_i;
          beat_d  = '0;
          hold_d  = '0;
          state_d = req_we_i ? WR : RD_HOLD;
        end
      end
      WR: begin
        if (last_beat) begin
          state_d = TURN;
        end else begin
          beat_d = beat_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      RD_HOLD: begin
        if (hold_done) state_d = RD_CAP;
        else           hold_d  = hold_q + 1'b1;
      end
      RD_CAP: begin
        rdata_d     = mem_data_io;
        rdata_vld_d = 1'b1;
        hold_d      = '0;
        if (last_beat) begin
          state_d = TURN;
        end else begin
          beat_d  = beat_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = RD_HOLD;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      hold_q      <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
    end
  end

  assign mem_write_o = (state_q == WR);
  assign mem_read_o  = (state_q == RD_HOLD) || (state_q == RD_CAP);
  assign wdata_ack_o = (state_q == WR);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == TURN);
  assign mem_addr_o  = addr_q;
  assign rdata_o     = rdata_q;
  assign rdata_vld_o = rdata_vld_q;

  // The bus is driven only while writing; write data passes straight through.
  assign mem_data_io = mem_write_o ? wdata_i : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural MEMORY_64MB model
// that parks a known word on DATA whenever the master is not writing.
module tb_mem_bus_master;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_i = 1'b0;
  logic          req_we_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic [DW-1:0] wdata_i = '1;
  logic          wdata_ack_o, rdata_vld_o, busy_o, done_o, mem_read_o, mem_write_o;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] mem_addr_o;
  wire  [DW-1:0] mem_data;

  mem_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .wdata_i(wdata_i), .wdata_ack_o(wdata_ack_o), .rdata_o(rdata_o),
    .rdata_vld_o(rdata_vld_o), .busy_o(busy_o), .done_o(done_o), .mem_addr_o(mem_addr_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_data_io(mem_data));

  always #5 clk = ~clk;

  // Memory model: writes land at the rising edge; the parked/read word is
  // refreshed shortly after each edge. Idle wdata_i is all-ones, so a master
  // that drives DATA outside WRITE corrupts the parked word.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] resp = 32'hDEAD_BEEF;
  assign mem_data = mem_write_o ? {DW{1'bz}} : resp;

  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  always begin
    @(posedge clk);
    if (mem_write_o) mem[mem_addr_o] = mem_data;
    #2;
    resp = lookup(mem_addr_o);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  int  done_q[$];
  int  ack_cnt = 0;

  // Per-cycle bus protocol checks and event logging, sampled mid-cycle.
  always @(negedge clk) begin
    check("rw_exclusive", 64'(mem_read_o & mem_write_o), 64'd0);
    check("ack_with_write", 64'(wdata_ack_o), 64'(mem_write_o));
    if (mem_write_o) begin
      check("wr_bus_data", 64'(mem_data), 64'(wdata_i));
      wr_q.push_back('{cyc, mem_addr_o, mem_data});
    end else begin
      check("bus_released", 64'(mem_data), 64'(resp));
    end
    if (wdata_ack_o) ack_cnt++;
    if (done_o) done_q.push_back(cyc);
    if (rdata_vld_o) rd_q.push_back('{cyc, mem_addr_o, rdata_o});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    ack_cnt = 0;
  endtask

  logic [DW-1:0] wsrc[$];

  task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] len);
    int idx = 0;
    int budget = 0;
    logic acked;
    req_i = 1'b1; req_we_i = 1'b1; req_addr_i = a; req_len_i = len;
    wdata_i = wsrc[0];
    tick();
    req_i = 1'b0;
    check("wr_busy_after_accept", 64'(busy_o), 64'd1);
    while (!done_o && budget < 40) begin
      acked = wdata_ack_o;
      tick();
      budget++;
      if (acked) begin
        idx++;
        wdata_i = (idx < wsrc.size()) ? wsrc[idx] : '1;
      end
    end
    check("wr_done_within_budget", 64'(budget < 40), 64'd1);
    tick();
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] len);
    int budget = 0;
    req_i = 1'b1; req_we_i = 1'b0; req_addr_i = a; req_len_i = len;
    tick();
    req_i = 1'b0;
    check("rd_busy_after_accept", 64'(busy_o), 64'd1);
    while (!done_o && budget < 80) begin
      tick();
      budget++;
    end
    check("rd_done_within_budget", 64'(budget < 80), 64'd1);
    tick();
  endtask

  initial begin
    int k0;
    int budget;
    for (int i = 0; i < 16; i++) mem[26'h1000 + AW'(i)] = 32'h0041_4020 + DW'(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", 64'(mem_read_o), 64'd0);
    check("rst_write", 64'(mem_write_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rdata_vld", 64'(rdata_vld_o), 64'd0);
    check("rst_ack", 64'(wdata_ack_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy_o), 64'd0);

    // Write burst 1..9 at address 1
    clear_logs();
    wsrc = '{};
    for (int i = 1; i <= 9; i++) wsrc.push_back(DW'(i));
    run_write(26'h000_0001, 4'd8);
    check("wb_beats", 64'(wr_q.size()), 64'd9);
    check("wb_acks", 64'(ack_cnt), 64'd9);
    if (wr_q.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("wb_addr[%0d]", i), 64'(wr_q[i].a), 64'(1 + i));
        check($sformatf("wb_data[%0d]", i), 64'(wr_q[i].d), 64'(1 + i));
        check($sformatf("wb_cyc[%0d]", i), 64'(wr_q[i].cyc - wr_q[0].cyc), 64'(i));
      end
      check("wb_done_cnt", 64'(done_q.size()), 64'd1);
      if (done_q.size() == 1) check("wb_done_cyc", 64'(done_q[0] - wr_q[8].cyc), 64'd1);
    end
    check("wb_idle_busy", 64'(busy_o), 64'd0);
    check("wb_addr_hold", 64'(mem_addr_o), 64'd9);

    // Read back words 1..9
    clear_logs();
    run_read(26'h000_0001, 4'd8);
    check("rb_beats", 64'(rd_q.size()), 64'd9);
    if (rd_q.size() == 9)
      for (int i = 0; i < 9; i++) check($sformatf("rb_data[%0d]", i), 64'(rd_q[i].d), 64'(1 + i));
    check("rb_wr_beats", 64'(wr_q.size()), 64'd0);

    // Read burst of the preloaded block, 16 beats
    clear_logs();
    run_read(26'h000_1000, 4'd15);
    check("rd16_beats", 64'(rd_q.size()), 64'd16);
    check("rd16_done_cnt", 64'(done_q.size()), 64'd1);
    if (rd_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("rd16_data[%0d]", i), 64'(rd_q[i].d), 64'(32'h0041_4020 + i));
        if (i > 0) check($sformatf("rd16_gap[%0d]", i), 64'(rd_q[i].cyc - rd_q[i-1].cyc), 64'd2);
      end
    end

    // Address wrap at the top of memory
    clear_logs();
    wsrc = '{32'hAAAA_0001, 32'hBBBB_0002};
    run_write(26'h3FF_FFFF, 4'd1);
    check("wrap_beats", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() == 2) begin
      check("wrap_addr0", 64'(wr_q[0].a), 64'h3FF_FFFF);
      check("wrap_addr1", 64'(wr_q[1].a), 64'h000_0000);
    end
    clear_logs();
    run_read(26'h3FF_FFFF, 4'd1);
    check("wrap_rb_beats", 64'(rd_q.size()), 64'd2);
    if (rd_q.size() == 2) begin
      check("wrap_rb0", 64'(rd_q[0].d), 64'hAAAA_0001);
      check("wrap_rb1", 64'(rd_q[1].d), 64'hBBBB_0002);
    end

    // REQ held high across a burst: the next burst starts only after DONE
    clear_logs();
    k0 = cyc;
    req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 26'h000_0020; req_len_i = 4'd1;
    wdata_i = 32'h0000_0077;
    repeat (5) tick();
    req_i = 1'b0;
    repeat (4) tick();
    wdata_i = '1;
    check("cont_beats", 64'(wr_q.size()), 64'd4);
    if (wr_q.size() == 4) begin
      check("cont_cyc0", 64'(wr_q[0].cyc - k0), 64'd1);
      check("cont_cyc1", 64'(wr_q[1].cyc - k0), 64'd2);
      check("cont_cyc2", 64'(wr_q[2].cyc - k0), 64'd5);
      check("cont_cyc3", 64'(wr_q[3].cyc - k0), 64'd6);
    end
    check("cont_done_cnt", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2) begin
      check("cont_done0", 64'(done_q[0] - k0), 64'd3);
      check("cont_done1", 64'(done_q[1] - k0), 64'd7);
    end
    check("cont_idle", 64'(busy_o), 64'd0);

    // Reset during beat 3 of an 8-beat read
    clear_logs();
    req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 26'h000_1000; req_len_i = 4'd7;
    tick();
    req_i = 1'b0;
    budget = 0;
    while (rd_q.size() < 2 && budget < 20) begin
      tick();
      budget++;
    end
    check("abort_reach_beat3", 64'(budget < 20), 64'd1);
    check("abort_in_read", 64'(mem_read_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_read", 64'(mem_read_o), 64'd0);
    check("abort_write", 64'(mem_write_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_vld", 64'(rdata_vld_o), 64'd0);
    check("abort_addr", 64'(mem_addr_o), 64'd0);
    check("abort_rdata", 64'(rdata_o), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("abort_no_done", 64'(done_q.size()), 64'd0);
    check("abort_no_more_beats", 64'(rd_q.size()), 64'd2);
    clear_logs();
    run_read(26'h000_1005, 4'd0);
    check("post_abort_beats", 64'(rd_q.size()), 64'd1);
    if (rd_q.size() == 1) check("post_abort_data", 64'(rd_q[0].d), 64'h0041_4025);
    check("post_abort_done", 64'(done_q.size()), 64'd1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
